// File: rtl/mult_seq_nbit.sv
// Iterative shift-add multiplier: WIDTH-bit operands, 2*WIDTH-bit registered product.
// One partial-product bit per clock; valid/ready handshake on both the operand and product sides.
// Optional build macro MULT_SIGNED_EN switches x, y and z to two's complement by multiplying
// magnitudes and negating the result when the operand signs differ.
module mult_seq_nbit #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] z,
    output logic               busy
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_e;

    state_e               state_q, state_d;
    logic [2*WIDTH-1:0]   acc_q;
    logic [2*WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]     mlr_q;
    logic [CntW-1:0]      cnt_q;
    logic [2*WIDTH-1:0]   z_q;

    logic                 accept;
    logic                 last;
    logic [2*WIDTH-1:0]   acc_sum;
    logic [2*WIDTH-1:0]   z_final;
    logic [WIDTH-1:0]     x_op;
    logic [WIDTH-1:0]     y_op;

`ifdef MULT_SIGNED_EN
    logic                 sign_q;
    logic                 sign_in;

    // Magnitudes fit in WIDTH unsigned bits, including the most negative value.
    always_comb begin
        x_op    = x[WIDTH-1] ? -x : x;
        y_op    = y[WIDTH-1] ? -y : y;
        sign_in = x[WIDTH-1] ^ y[WIDTH-1];
        z_final = sign_q ? -acc_sum : acc_sum;
    end
`else
    // Unsigned build: operands pass straight through, no sign correction.
    always_comb begin
        x_op    = x;
        y_op    = y;
        z_final = acc_sum;
    end
`endif

    // Partial-product add and control decodes.
    always_comb begin
        acc_sum = acc_q + (mlr_q[0] ? mcand_q : '0);
        accept  = in_valid && (state_q == StIdle);
        last    = (state_q == StCalc) && (cnt_q == CntW'(WIDTH - 1));
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) state_d = StCalc;
            end
            StCalc: begin
                busy = 1'b1;
                if (last) state_d = StDone;
            end
            StDone: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // Datapath: latch operands on accept, shift-add in CALC, load product on the last step.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q   <= '0;
            mcand_q <= '0;
            mlr_q   <= '0;
            cnt_q   <= '0;
            z_q     <= '0;
`ifdef MULT_SIGNED_EN
            sign_q  <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        acc_q   <= '0;
                        mcand_q <= {{WIDTH{1'b0}}, x_op};
                        mlr_q   <= y_op;
                        cnt_q   <= '0;
`ifdef MULT_SIGNED_EN
                        sign_q  <= sign_in;
`endif
                    end
                end
                StCalc: begin
                    acc_q   <= acc_sum;
                    mcand_q <= mcand_q << 1;
                    mlr_q   <= mlr_q >> 1;
                    cnt_q   <= cnt_q + CntW'(1);
                    // z holds the previous product until this edge.
                    if (last) z_q <= z_final;
                end
                default: ;
            endcase
        end
    end

    assign z = z_q;

endmodule

// File: tb/tb_mult_seq_nbit.sv
// Bench for mult_seq_nbit: a WIDTH=8 and a WIDTH=16 instance, scoreboard of expected products.
// Honours MULT_SIGNED_EN the same way as the design.
module tb_mult_seq_nbit;

    logic clk;
    logic rst;

    logic        in_valid8, in_ready8, out_valid8, out_ready8, busy8;
    logic [7:0]  x8, y8;
    logic [15:0] z8;

    logic        in_valid16, in_ready16, out_valid16, out_ready16, busy16;
    logic [15:0] x16, y16;
    logic [31:0] z16;

    int checks = 0;
    int errors = 0;

    logic [31:0] q8[$];
    logic [31:0] q16[$];

    mult_seq_nbit #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .x         (x8),
        .y         (y8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .z         (z8),
        .busy      (busy8)
    );

    mult_seq_nbit #(.WIDTH(16)) dut16 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid16),
        .in_ready  (in_ready16),
        .x         (x16),
        .y         (y16),
        .out_valid (out_valid16),
        .out_ready (out_ready16),
        .z         (z16),
        .busy      (busy16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model8(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] r;
`ifdef MULT_SIGNED_EN
        r = $signed({{8{a[7]}}, a}) * $signed({{8{b[7]}}, b});
`else
        r = {8'd0, a} * {8'd0, b};
`endif
        return {16'd0, r};
    endfunction

    function automatic logic [31:0] model16(input logic [15:0] a, input logic [15:0] b);
        logic [31:0] r;
`ifdef MULT_SIGNED_EN
        r = $signed({{16{a[15]}}, a}) * $signed({{16{b[15]}}, b});
`else
        r = {16'd0, a} * {16'd0, b};
`endif
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One W=8 transaction; leaves the DUT in IDLE if out_ready8 is high, else in DONE.
    task automatic txn8(input logic [7:0] a, input logic [7:0] b);
        int cyc;
        logic [31:0] e;
        check("in_ready8_idle", {31'd0, in_ready8}, 32'd1);
        x8 = a; y8 = b; in_valid8 = 1'b1;
        q8.push_back(model8(a, b));
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        x8 = 8'($urandom); y8 = 8'($urandom);
        check("busy8_calc", {30'd0, busy8, in_ready8}, 32'd2);
        cyc = 0;
        while (!out_valid8 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("latency8", cyc, 32'd8);
        e = (q8.size() > 0) ? q8.pop_front() : 32'hxxxx_xxxx;
        check("z8", {16'd0, z8}, e);
        if (out_ready8) begin
            @(posedge clk); #1;
            check("idle8_after", {30'd0, out_valid8, in_ready8}, 32'd1);
        end
    endtask

    task automatic txn16(input logic [15:0] a, input logic [15:0] b);
        int cyc;
        logic [31:0] e;
        x16 = a; y16 = b; in_valid16 = 1'b1;
        q16.push_back(model16(a, b));
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        x16 = 16'($urandom); y16 = 16'($urandom);
        cyc = 0;
        while (!out_valid16 && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("latency16", cyc, 32'd16);
        e = (q16.size() > 0) ? q16.pop_front() : 32'hxxxx_xxxx;
        check("z16", z16, e);
        @(posedge clk); #1;
        check("idle16_after", {31'd0, in_ready16}, 32'd1);
    endtask

    initial begin
        int seen;
        logic [31:0] bp_exp;

        rst = 1'b1;
        in_valid8 = 1'b0; x8 = '0; y8 = '0; out_ready8 = 1'b1;
        in_valid16 = 1'b0; x16 = '0; y16 = '0; out_ready16 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_z8", {16'd0, z8}, 32'd0);
        check("rst_flags8", {29'd0, busy8, out_valid8, in_ready8}, 32'd1);
        check("rst_z16", z16, 32'd0);
        check("rst_flags16", {29'd0, busy16, out_valid16, in_ready16}, 32'd1);
        rst = 1'b0;

        // Directed W=8 vectors, back-to-back with out_ready held high.
        txn8(8'hFF, 8'hFF);
        txn8(8'h00, 8'hA5);
        txn8(8'h0C, 8'h0D);
        txn8(8'hFF, 8'h02);
        txn8(8'h80, 8'h80);
        txn8(8'h80, 8'h7F);
        txn8(8'h01, 8'hFF);

        // Backpressure in DONE, with a stray in_valid that must be ignored.
        out_ready8 = 1'b0;
        bp_exp = model8(8'h37, 8'h21);
        txn8(8'h37, 8'h21);
        for (int i = 0; i < 5; i++) begin
            in_valid8 = 1'b1;
            x8 = 8'($urandom); y8 = 8'($urandom);
            @(posedge clk); #1;
            check("bp_flags", {29'd0, busy8, out_valid8, in_ready8}, 32'd6);
            check("bp_z", {16'd0, z8}, bp_exp);
        end
        in_valid8 = 1'b0;
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        check("bp_release", {29'd0, busy8, out_valid8, in_ready8}, 32'd1);
        check("bp_z_hold", {16'd0, z8}, bp_exp);
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid8) seen++;
        end
        check("bp_no_queue", seen, 32'd0);

        // Reset during CALC discards the product.
        x8 = 8'h9B; y8 = 8'h57; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_flags", {29'd0, busy8, out_valid8, in_ready8}, 32'd1);
        check("midrst_z", {16'd0, z8}, 32'd0);
        seen = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (out_valid8) seen++;
        end
        check("midrst_no_stale", seen, 32'd0);
        txn8(8'h0C, 8'h0D);

        // W=16: corners then random pairs.
        txn16(16'hFFFF, 16'hFFFF);
        txn16(16'h0000, 16'h0000);
        txn16(16'h8000, 16'h8000);
        for (int i = 0; i < 200; i++) begin
            txn16(16'($urandom), 16'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
